// File: rtl/gpu_pkg.sv
// Shared constants, state encoding and command payload for the GPU blitter.
package gpu_pkg;

  localparam int unsigned PIX_W     = 12;
  localparam int unsigned ROM_DIM   = 256;
  localparam int unsigned COORD_W   = $clog2(ROM_DIM);  // ROM coordinate / size width
  localparam int unsigned ROM_AW    = 2 * COORD_W;      // {y, x}
  localparam int unsigned DST_W     = 9;                // framebuffer origin width
  localparam int unsigned SUM_W     = 10;               // dst + offset, never wraps
  localparam int unsigned FB_AW     = 17;
  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } blit_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] src_x;
    logic [COORD_W-1:0] src_y;
    logic [DST_W-1:0]   dst_x;
    logic [DST_W-1:0]   dst_y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic               key_en;
    logic [PIX_W-1:0]   key;
  } blit_cmd_t;

endpackage

// File: rtl/gpu_blit_addr_gen.sv
// Stage 1 of the blitter: walks the rectangle row-major, issuing one ROM read
// per pixel and carrying the matching destination coordinates.
//  load         : command accepted this edge; geometry inputs are live values
//  stall        : hold every register
//  src_*/dst_*  : rectangle origins; w/h rectangle size
//  rom_rd_en/rom_addr : registered ROM read
//  pix_dx/pix_dy      : registered destination coordinates of the issued pixel
//  issue_last_c       : the final pixel is being issued at this edge
module gpu_blit_addr_gen
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               stall,
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  input  logic [DST_W-1:0]   dst_x,
  input  logic [DST_W-1:0]   dst_y,
  input  logic [COORD_W-1:0] w,
  input  logic [COORD_W-1:0] h,
  output logic               rom_rd_en,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic [SUM_W-1:0]   pix_dx,
  output logic [SUM_W-1:0]   pix_dy,
  output logic               issue_last_c
);

  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               pending_q;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               have_pix;
  logic               x_end;
  logic               y_end;

  // On load the first pixel is issued straight from the incoming command.
  always_comb begin
    cur_x        = load ? '0 : x_q;
    cur_y        = load ? '0 : y_q;
    have_pix     = load ? ((w != '0) && (h != '0)) : pending_q;
    x_end        = (cur_x == COORD_W'(w - COORD_W'(1)));
    y_end        = (cur_y == COORD_W'(h - COORD_W'(1)));
    issue_last_c = have_pix && !stall && x_end && y_end;
  end

  // Issue register and scan counters; rom_addr holds when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= 1'b0;
      rom_rd_en <= 1'b0;
      rom_addr  <= '0;
      pix_dx    <= '0;
      pix_dy    <= '0;
    end else if (!stall) begin
      rom_rd_en <= have_pix;
      if (have_pix) begin
        rom_addr  <= {COORD_W'(src_y + cur_y), COORD_W'(src_x + cur_x)};
        pix_dx    <= SUM_W'(dst_x) + SUM_W'(cur_x);
        pix_dy    <= SUM_W'(dst_y) + SUM_W'(cur_y);
        x_q       <= x_end ? '0 : COORD_W'(cur_x + COORD_W'(1));
        y_q       <= x_end ? COORD_W'(cur_y + COORD_W'(1)) : cur_y;
        pending_q <= !(x_end && y_end);
      end
    end else if (load) begin
      // Accepted while the previous blit's last write is still stalled.
      x_q       <= '0;
      y_q       <= '0;
      pending_q <= (w != '0) && (h != '0);
    end
  end

endmodule

// File: rtl/gpu_blit_ctrl.sv
// GPU rectangle blitter: copies a ROM rectangle into the framebuffer with
// optional colour-key transparency and screen clipping.
//  cmd_*        : command handshake and payload (latched on acceptance)
//  rom_*        : combinational-read pixel ROM port
//  fb_*         : framebuffer write port with fb_ready back-pressure
//  busy / done  : activity flag and one-cycle completion pulse
module gpu_blit_ctrl
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_src_x,
  input  logic [COORD_W-1:0] cmd_src_y,
  input  logic [DST_W-1:0]   cmd_dst_x,
  input  logic [DST_W-1:0]   cmd_dst_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic               cmd_key_en,
  input  logic [PIX_W-1:0]   cmd_key,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_rd_en,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [PIX_W-1:0]   fb_wdata,
  input  logic               fb_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned LIN_W = FB_AW + 2;  // wide enough for any dst_y*stride+dst_x

  blit_state_e        state_q;
  blit_state_e        state_d;
  logic               done_d;
  blit_cmd_t          cmd_in;
  blit_cmd_t          cmd_q;
  blit_cmd_t          cmd_live;
  logic               accept;
  logic               stall;
  logic               empty;
  logic               issue_last_c;
  logic [SUM_W-1:0]   pix_dx;
  logic [SUM_W-1:0]   pix_dy;
  logic [LIN_W-1:0]   fb_lin;
  logic               clip;
  logic               key_hit;

  // Handshake and command selection (live inputs on the accepting edge).
  always_comb begin
    cmd_in.src_x  = cmd_src_x;
    cmd_in.src_y  = cmd_src_y;
    cmd_in.dst_x  = cmd_dst_x;
    cmd_in.dst_y  = cmd_dst_y;
    cmd_in.w      = cmd_w;
    cmd_in.h      = cmd_h;
    cmd_in.key_en = cmd_key_en;
    cmd_in.key    = cmd_key;
    accept        = cmd_valid && cmd_ready;
    stall         = fb_we && !fb_ready;
    empty         = (cmd_w == '0) || (cmd_h == '0);
    cmd_live      = accept ? cmd_in : cmd_q;
  end

  gpu_blit_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .stall        (stall),
    .src_x        (cmd_live.src_x),
    .src_y        (cmd_live.src_y),
    .dst_x        (cmd_live.dst_x),
    .dst_y        (cmd_live.dst_y),
    .w            (cmd_live.w),
    .h            (cmd_live.h),
    .rom_rd_en    (rom_rd_en),
    .rom_addr     (rom_addr),
    .pix_dx       (pix_dx),
    .pix_dy       (pix_dy),
    .issue_last_c (issue_last_c)
  );

  // Next-state logic; FLUSH leaves on the first unstalled edge, which drains stage 1.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (empty || issue_last_c) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (issue_last_c) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!stall) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, status outputs and command latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      if (accept) begin
        cmd_q <= cmd_in;
      end
    end
  end

  // Clip and colour-key decisions for the pixel currently read from ROM.
  always_comb begin
    fb_lin  = LIN_W'(pix_dy) * LIN_W'(FB_WIDTH) + LIN_W'(pix_dx);
    clip    = (pix_dx >= SUM_W'(FB_WIDTH)) || (pix_dy >= SUM_W'(FB_HEIGHT));
    key_hit = cmd_q.key_en && (rom_data == cmd_q.key);
  end

  // Stage 2 write register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_wdata <= '0;
    end else if (!stall) begin
      fb_we <= rom_rd_en && !clip && !key_hit;
      if (rom_rd_en) begin
        fb_addr  <= FB_AW'(fb_lin);
        fb_wdata <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_gpu_blit_ctrl.sv
`timescale 1ns/1ps
module tb_gpu_blit_ctrl;
  import gpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [7:0]         cmd_src_x = '0, cmd_src_y = '0, cmd_w = '0, cmd_h = '0;
  logic [8:0]         cmd_dst_x = '0, cmd_dst_y = '0;
  logic               cmd_key_en = 1'b0;
  logic [PIX_W-1:0]   cmd_key = '0;
  logic [ROM_AW-1:0]  rom_addr;
  logic               rom_rd_en;
  logic [PIX_W-1:0]   rom_data;
  logic               fb_we;
  logic [FB_AW-1:0]   fb_addr;
  logic [PIX_W-1:0]   fb_wdata;
  logic               fb_ready = 1'b1;
  logic               busy;
  logic               done;

  logic [PIX_W-1:0] rom_mem [0:65535];
  assign rom_data = rom_mem[rom_addr];

  always #5 clk = ~clk;

  gpu_blit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y), .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y),
    .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_key_en(cmd_key_en), .cmd_key(cmd_key),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  typedef struct { int sx; int sy; int dx; int dy; int w; int h; bit key_en; int key; } blit_s;
  typedef struct { int addr; int data; } wr_s;

  int  exp_reads[$];
  wr_s exp_w[$];
  int  obs_reads[$];
  wr_s obs_w[$];
  int  obs_wcyc[$];
  int  done_cyc, exp_done, early_ready, wait_n;
  int  smp_we[0:255], smp_addr[0:255], smp_data[0:255], smp_rd[0:255], smp_busy[0:255];
  int  errors = 0;
  int  checks = 0;

  // Reference: every pixel of the rectangle, in scan order, with clip/key rules.
  function automatic void build_model(input blit_s b);
    exp_reads.delete();
    exp_w.delete();
    for (int y = 0; y < b.h; y++) begin
      for (int x = 0; x < b.w; x++) begin
        int ra, px, ddx, ddy;
        wr_s wr;
        ra  = ((b.sy + y) % 256) * 256 + ((b.sx + x) % 256);
        px  = int'(rom_mem[ra]);
        ddx = b.dx + x;
        ddy = b.dy + y;
        exp_reads.push_back(ra);
        if (ddx < 320 && ddy < 240 && !(b.key_en && px == b.key)) begin
          wr.addr = (ddy * 320 + ddx) % 131072;
          wr.data = px;
          exp_w.push_back(wr);
        end
      end
    end
  endfunction

  task automatic drive_cmd(input blit_s b);
    cmd_src_x  = 8'(b.sx);
    cmd_src_y  = 8'(b.sy);
    cmd_dst_x  = 9'(b.dx);
    cmd_dst_y  = 9'(b.dy);
    cmd_w      = 8'(b.w);
    cmd_h      = 8'(b.h);
    cmd_key_en = b.key_en;
    cmd_key    = 12'(b.key);
  endtask

  task automatic record(input int c);
    wr_s wr;
    if (c < 256) begin
      smp_we[c] = int'(fb_we); smp_addr[c] = int'(fb_addr); smp_data[c] = int'(fb_wdata);
      smp_rd[c] = int'(rom_rd_en); smp_busy[c] = int'(busy);
    end
    if (rom_rd_en && !(fb_we && !fb_ready)) obs_reads.push_back(int'(rom_addr));
    if (fb_we && fb_ready) begin
      wr.addr = int'(fb_addr); wr.data = int'(fb_wdata);
      obs_w.push_back(wr); obs_wcyc.push_back(c);
    end
  endtask

  // Offers b, then samples each cycle (cycle 1 = first after acceptance) until done.
  // mode 0: fb_ready=1; 1: random fb_ready; 2: fb_ready low in cycles 4..6.
  task automatic run_blit(input blit_s b, input int mode, input bit hold, input blit_s nb);
    int c;
    bit pend;
    build_model(b);
    obs_reads.delete(); obs_w.delete(); obs_wcyc.delete();
    done_cyc = -1; early_ready = 0; wait_n = 0;
    exp_done = (b.w == 0 || b.h == 0) ? 2 : b.w * b.h + 1;
    drive_cmd(b);
    cmd_valid = 1'b1;
    fb_ready  = 1'b1;
    while (!cmd_ready && wait_n < 2000) begin
      @(negedge clk);
      wait_n++;
    end
    @(posedge clk); #1;
    if (hold) drive_cmd(nb); else cmd_valid = 1'b0;
    c = 1;
    while (done_cyc < 0 && c < 2000) begin
      case (mode)
        0:       fb_ready = 1'b1;
        1:       fb_ready = (($urandom % 4) != 0);
        default: fb_ready = !(c >= 4 && c <= 6);
      endcase
      @(negedge clk);
      record(c);
      if (done) done_cyc = c;
      else if (cmd_ready) early_ready++;
      // Each stalled write before completion pushes completion back one cycle.
      if (fb_we && !fb_ready && c < exp_done) exp_done++;
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        c++;
      end
    end
    pend = fb_we && !fb_ready;
    while (pend && c < 2100) begin
      @(posedge clk); #1;
      fb_ready = 1'b1;
      c++;
      @(negedge clk);
      record(c);
      pend = fb_we && !fb_ready;
    end
  endtask

  task automatic cmp_writes(input string nm);
    checks++;
    if (obs_w.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL %s_write_count got %0d want %0d", nm, obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      checks++;
      if (obs_w[i].addr !== exp_w[i].addr || obs_w[i].data !== exp_w[i].data) begin
        errors++;
        $display("FAIL %s_write[%0d] got addr=%0d data=%h want addr=%0d data=%h", nm, i,
                 obs_w[i].addr, obs_w[i].data, exp_w[i].addr, exp_w[i].data);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, fb_we, rom_rd_en} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000", {cmd_ready, busy, done, fb_we, rom_rd_en});
    end
    checks++;
    if ({rom_addr, fb_addr, fb_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_buses got rom=%h fb=%h wd=%h want 0", rom_addr, fb_addr, fb_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    blit_s b;
    int want_ra[4];
    int want_fa[4];
    b = '{0, 0, 0, 0, 2, 2, 1'b0, 0};
    want_ra = '{0, 1, 256, 257};
    want_fa = '{0, 1, 320, 321};
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (smp_rd[1] !== 1 || smp_we[1] !== 0 || smp_we[2] !== 1) begin
      errors++;
      $display("FAIL basic_latency got rd1=%0d we1=%0d we2=%0d want 1 0 1", smp_rd[1], smp_we[1], smp_we[2]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= obs_reads.size() || obs_reads[i] !== want_ra[i]) begin
        errors++;
        $display("FAIL basic_rom_addr[%0d] got %h want %h", i, (i < obs_reads.size()) ? obs_reads[i] : -1, want_ra[i]);
      end
      checks++;
      if (i >= obs_w.size() || obs_w[i].addr !== want_fa[i] || obs_w[i].data !== int'(rom_mem[want_ra[i]])
          || obs_wcyc[i] !== i + 2) begin
        errors++;
        $display("FAIL basic_write[%0d] got addr=%0d cyc=%0d want addr=%0d cyc=%0d", i,
                 (i < obs_w.size()) ? obs_w[i].addr : -1, (i < obs_w.size()) ? obs_wcyc[i] : -1, want_fa[i], i + 2);
      end
    end
    checks++;
    if (done_cyc !== 5 || early_ready !== 0) begin
      errors++;
      $display("FAIL basic_done got cyc=%0d early_ready=%0d want cyc=5 early_ready=0", done_cyc, early_ready);
    end
  endtask

  task automatic test_wrap();
    blit_s b;
    b = '{250, 0, 20, 3, 10, 1, 1'b0, 0};
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (obs_reads.size() !== 10) begin
      errors++;
      $display("FAIL wrap_read_count got %0d want 10", obs_reads.size());
    end
    for (int i = 0; i < 10 && i < obs_reads.size(); i++) begin
      checks++;
      if (obs_reads[i] !== (250 + i) % 256) begin
        errors++;
        $display("FAIL wrap_rom_addr[%0d] got %h want %h", i, obs_reads[i], (250 + i) % 256);
      end
    end
    cmp_writes("wrap");
    checks++;
    if (done_cyc !== 11) begin
      errors++;
      $display("FAIL wrap_done got %0d want 11", done_cyc);
    end
  endtask

  task automatic test_clip();
    blit_s b;
    b = '{20, 30, 315, 238, 8, 8, 1'b0, 0};
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (obs_w.size() !== 10) begin
      errors++;
      $display("FAIL clip_count got %0d want 10", obs_w.size());
    end
    cmp_writes("clip");
    checks++;
    if (done_cyc !== 65 || obs_reads.size() !== 64) begin
      errors++;
      $display("FAIL clip_done got cyc=%0d reads=%0d want cyc=65 reads=64", done_cyc, obs_reads.size());
    end
  endtask

  task automatic test_key();
    blit_s b;
    int hits;
    b = '{40, 7, 100, 50, 4, 1, 1'b1, 12'hF0F};
    rom_mem[7*256+40] = 12'h123;
    rom_mem[7*256+41] = 12'hF0F;
    rom_mem[7*256+42] = 12'h0F0;
    rom_mem[7*256+43] = 12'h456;
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (obs_w.size() !== 3) begin
      errors++;
      $display("FAIL key_count got %0d want 3", obs_w.size());
    end
    hits = 0;
    foreach (obs_w[i]) if (obs_w[i].addr == 50 * 320 + 101) hits++;
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("FAIL key_keyed_addr_written got %0d want 0", hits);
    end
    cmp_writes("key");
  endtask

  task automatic test_stall();
    blit_s b;
    b = '{5, 9, 10, 10, 4, 4, 1'b0, 0};
    run_blit(b, 2, 1'b0, b);
    for (int c = 4; c <= 7; c++) begin
      checks++;
      if (smp_we[c] !== 1 || smp_addr[c] !== exp_w[2].addr || smp_data[c] !== exp_w[2].data) begin
        errors++;
        $display("FAIL stall_hold[c%0d] got we=%0d addr=%0d data=%h want we=1 addr=%0d data=%h", c,
                 smp_we[c], smp_addr[c], smp_data[c], exp_w[2].addr, exp_w[2].data);
      end
    end
    cmp_writes("stall");
    checks++;
    if (done_cyc !== 20) begin
      errors++;
      $display("FAIL stall_done got %0d want 20", done_cyc);
    end
  endtask

  task automatic test_empty();
    blit_s b;
    b = '{3, 4, 5, 6, 0, 5, 1'b0, 0};
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (done_cyc !== 2 || smp_busy[1] !== 1) begin
      errors++;
      $display("FAIL empty_done got cyc=%0d busy1=%0d want cyc=2 busy1=1", done_cyc, smp_busy[1]);
    end
    checks++;
    if ((smp_rd[1] | smp_rd[2] | smp_we[1] | smp_we[2]) !== 0 || obs_w.size() !== 0) begin
      errors++;
      $display("FAIL empty_activity got rd=%0d%0d we=%0d%0d writes=%0d want none",
               smp_rd[1], smp_rd[2], smp_we[1], smp_we[2], obs_w.size());
    end
  endtask

  task automatic test_back_to_back();
    blit_s a, b;
    a = '{60, 61, 0, 100, 3, 2, 1'b0, 0};
    b = '{200, 10, 300, 5, 2, 2, 1'b1, int'(rom_mem[10*256+201])};
    run_blit(a, 0, 1'b1, b);
    checks++;
    if (early_ready !== 0 || done_cyc !== 7) begin
      errors++;
      $display("FAIL b2b_first got early_ready=%0d done=%0d want 0 7", early_ready, done_cyc);
    end
    cmp_writes("b2b_a");
    run_blit(b, 0, 1'b0, b);
    checks++;
    if (wait_n !== 0 || done_cyc !== 5) begin
      errors++;
      $display("FAIL b2b_second got wait=%0d done=%0d want 0 5", wait_n, done_cyc);
    end
    cmp_writes("b2b_b");
  endtask

  task automatic test_reset_mid();
    blit_s b;
    int bad, waits;
    b = '{0, 0, 0, 0, 8, 8, 1'b0, 0};
    drive_cmd(b);
    cmd_valid = 1'b1;
    fb_ready  = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 2000) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, done, fb_we, rom_rd_en} !== 5'b10000 || {rom_addr, fb_addr, fb_wdata} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got flags=%b rom=%h fb=%h want 10000 and zero buses",
               {cmd_ready, busy, done, fb_we, rom_rd_en}, rom_addr, fb_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (done || fb_we || rom_rd_en || busy || !cmd_ready) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    blit_s b;
    for (int n = 0; n < 14; n++) begin
      b.sx = $urandom_range(0, 255);
      b.sy = $urandom_range(0, 255);
      b.dx = ($urandom % 3 == 0) ? $urandom_range(0, 511) : $urandom_range(280, 330);
      b.dy = ($urandom % 3 == 0) ? $urandom_range(0, 511) : $urandom_range(220, 250);
      b.w  = $urandom_range(0, 12);
      b.h  = $urandom_range(0, 6);
      b.key_en = 1'($urandom);
      b.key = ($urandom % 2 == 1) ? int'(rom_mem[b.sy * 256 + b.sx]) : int'(12'($urandom));
      run_blit(b, 1, 1'b0, b);
      checks++;
      if (obs_reads.size() !== exp_reads.size()) begin
        errors++;
        $display("FAIL rand%0d_read_count got %0d want %0d", n, obs_reads.size(), exp_reads.size());
      end
      for (int i = 0; i < exp_reads.size() && i < obs_reads.size(); i++) begin
        checks++;
        if (obs_reads[i] !== exp_reads[i]) begin
          errors++;
          $display("FAIL rand%0d_rom_addr[%0d] got %h want %h", n, i, obs_reads[i], exp_reads[i]);
        end
      end
      cmp_writes($sformatf("rand%0d", n));
      checks++;
      if (done_cyc !== exp_done) begin
        errors++;
        $display("FAIL rand%0d_done got %0d want %0d", n, done_cyc, exp_done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom_mem[i] = 12'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_clip();
    test_key();
    test_stall();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
